// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
// States, requester ids and the latched operation kind.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester wins outright,
// a tie goes to whichever requester was not granted last.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_ICACHE;
        unique case (req)
            2'b01:   gnt_id = REQ_ICACHE;
            2'b10:   gnt_id = REQ_DCACHE;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = REQ_ICACHE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache (0) and dcache (1): one latched
// transaction at a time, round-robin on ties, watchdog abort on no ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_read_enable,
    input  logic                  r0_write_enable,
    input  logic [ADDR_WIDTH-1:0] r0_address,
    input  logic [DATA_WIDTH-1:0] r0_write_value,
    output logic [DATA_WIDTH-1:0] r0_read_value,
    output logic                  r0_valid,
    input  logic                  r1_read_enable,
    input  logic                  r1_write_enable,
    input  logic [ADDR_WIDTH-1:0] r1_address,
    input  logic [DATA_WIDTH-1:0] r1_write_value,
    output logic [DATA_WIDTH-1:0] r1_read_value,
    output logic                  r1_valid,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_value,
    input  logic [DATA_WIDTH-1:0] mem_read_value,
    input  logic                  mem_valid,
    output logic                  timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                state;
    op_t                   op;
    logic                  id;
    logic                  last_grant;
    logic [CW-1:0]         wd_cnt;
    logic [CW-1:0]         wd_next;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            req;
    logic                  gnt_valid;
    logic                  gnt_id;
    logic                  wr_sel;
    logic                  abort;

    assign req = {r1_read_enable | r1_write_enable,
                  r0_read_enable | r0_write_enable};

    // Write takes priority when a requester raises both enables.
    assign wr_sel = gnt_id ? r1_write_enable : r0_write_enable;

    assign wd_next = (wd_cnt == '1) ? wd_cnt : wd_cnt + CW'(1);
    assign abort   = (TIMEOUT_CYCLES != 0) && (wd_next == CW'(TIMEOUT_CYCLES));

    assign r0_read_value = rdata;
    assign r1_read_value = rdata;

    rr_pick2 u_pick (
        .req        (req),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            op               <= OP_READ;
            id               <= REQ_ICACHE;
            last_grant       <= REQ_DCACHE;
            wd_cnt           <= '0;
            rdata            <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_value  <= '0;
            r0_valid         <= 1'b0;
            r1_valid         <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        id <= gnt_id;
                        if (req == 2'b11)
                            last_grant <= gnt_id;
                        op               <= wr_sel ? OP_WRITE : OP_READ;
                        mem_address      <= gnt_id ? r1_address : r0_address;
                        mem_write_value  <= gnt_id ? r1_write_value
                                                   : r0_write_value;
                        mem_write_enable <= wr_sel;
                        mem_read_enable  <= ~wr_sel;
                        wd_cnt           <= '0;
                        state            <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the watchdog's last cycle still completes normally.
                    if (mem_valid || abort) begin
                        mem_read_enable  <= 1'b0;
                        mem_write_enable <= 1'b0;
                        rdata            <= (mem_valid && op == OP_READ)
                                            ? mem_read_value : '0;
                        timeout_err      <= ~mem_valid;
                        r0_valid         <= (id == REQ_ICACHE);
                        r1_valid         <= (id == REQ_DCACHE);
                        state            <= DONE;
                    end else begin
                        wd_cnt <= wd_next;
                    end
                end
                DONE: begin
                    r0_valid    <= 1'b0;
                    r1_valid    <= 1'b0;
                    timeout_err <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester and memory models,
// expected completions queued at issue and checked by a monitor.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          r0_read_enable = 1'b0, r0_write_enable = 1'b0;
    logic [AW-1:0] r0_address = '0;
    logic [DW-1:0] r0_write_value = '0;
    logic [DW-1:0] r0_read_value;
    logic          r0_valid;
    logic          r1_read_enable = 1'b0, r1_write_enable = 1'b0;
    logic [AW-1:0] r1_address = '0;
    logic [DW-1:0] r1_write_value = '0;
    logic [DW-1:0] r1_read_value;
    logic          r1_valid;
    logic          mem_read_enable, mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_value;
    logic [DW-1:0] mem_read_value;
    logic          mem_valid = 1'b0;
    logic          timeout_err;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk              (clk),
        .reset            (reset),
        .r0_read_enable   (r0_read_enable),
        .r0_write_enable  (r0_write_enable),
        .r0_address       (r0_address),
        .r0_write_value   (r0_write_value),
        .r0_read_value    (r0_read_value),
        .r0_valid         (r0_valid),
        .r1_read_enable   (r1_read_enable),
        .r1_write_enable  (r1_write_enable),
        .r1_address       (r1_address),
        .r1_write_value   (r1_write_value),
        .r1_read_value    (r1_read_value),
        .r1_valid         (r1_valid),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_value  (mem_write_value),
        .mem_read_value   (mem_read_value),
        .mem_valid        (mem_valid),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        int          en;
        logic        wr;
        logic        tmo;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
    } req_t;

    exp_t sb[$];
    req_t q0[$];
    req_t q1[$];
    int   vt[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    int          lat = 0;
    bit          always_ack = 0;
    bit          use_fn = 0;
    logic [31:0] rdata = '0;
    int          mcnt = 0;

    assign mem_read_value = use_fn ? {mem_address[15:0], 16'hC0DE} : rdata;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model: ack after 'lat' enabled cycles (0 = never), or always.
    always @(posedge clk) begin
        #1;
        if (mem_read_enable || mem_write_enable) mcnt++;
        else mcnt = 0;
        mem_valid = always_ack || (lat != 0 && mcnt == lat);
    end

    // Requesters: hold the head request until its valid, then move on.
    always @(negedge clk) begin
        if (r0_valid && q0.size() > 0) void'(q0.pop_front());
        if (r1_valid && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            r0_address = q0[0].addr; r0_write_value = q0[0].wdata;
            r0_read_enable = q0[0].rd; r0_write_enable = q0[0].wr;
        end else begin
            r0_read_enable = 1'b0; r0_write_enable = 1'b0;
        end
        if (q1.size() > 0) begin
            r1_address = q1[0].addr; r1_write_value = q1[0].wdata;
            r1_read_enable = q1[0].rd; r1_write_enable = q1[0].wr;
        end else begin
            r1_read_enable = 1'b0; r1_write_enable = 1'b0;
        end
    end

    int          en_cnt = 0;
    bit          saw_rd = 0, saw_wr = 0;
    logic [31:0] addr_seen = '0, wd_seen = '0;

    // Monitor: pops the scoreboard on every completion pulse.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            en_cnt = 0; saw_rd = 0; saw_wr = 0;
        end else begin
            if (mem_read_enable || mem_write_enable) begin
                if (en_cnt == 0) begin
                    addr_seen = mem_address; wd_seen = mem_write_value;
                end
                en_cnt++;
                saw_rd |= mem_read_enable;
                saw_wr |= mem_write_enable;
            end
            if (r0_valid || r1_valid) begin
                vt.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid actual=%b%b expected=00",
                             r1_valid, r0_valid);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_onehot", 32'(r0_valid & r1_valid), 0);
                    chk("valid_id", 32'(r1_valid), 32'(e.id));
                    chk("read_value", e.id ? r1_read_value : r0_read_value,
                        e.data);
                    chk("enable_cycles", en_cnt, e.en);
                    chk("mem_address", addr_seen, e.addr);
                    if (e.wr) chk("mem_write_value", wd_seen, e.wdata);
                    chk("write_strobe", 32'(saw_wr), 32'(e.wr));
                    chk("read_strobe", 32'(saw_rd), 32'(!e.wr));
                    chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
                end
                en_cnt = 0; saw_rd = 0; saw_wr = 0;
            end else if (timeout_err) begin
                checks++; failures++;
                $display("FAIL stray_timeout actual=1 expected=0");
            end
        end
    end

    task automatic issue(bit id, logic [31:0] addr, logic [31:0] wdata,
                         bit rd, bit wr, int en, bit tmo, logic [31:0] data);
        req_t r;
        exp_t e;
        r.addr = addr; r.wdata = wdata; r.rd = rd; r.wr = wr;
        e.id = id; e.addr = addr; e.wdata = wdata; e.data = data;
        e.en = en; e.wr = wr; e.tmo = tmo;
        if (id) q1.push_back(r);
        else q0.push_back(r);
        sb.push_back(e);
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while ((sb.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=pending expected=drained", name);
            sb.delete(); q0.delete(); q1.delete();
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        req_t r;
        int   n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(mem_read_enable), 0);
        chk("rst_wr_en", 32'(mem_write_enable), 0);
        chk("rst_valid", {30'b0, r1_valid, r0_valid}, 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_write_value, 0);
        chk("rst_rvalue", r0_read_value | r1_read_value, 0);
        #1 reset = 1'b0;
        @(posedge clk); #2;

        // Single read, ack after 3 enabled cycles.
        lat = 3; rdata = 32'hDEAD_BEEF;
        issue(0, 32'h0000_1000, 0, 1, 0, 3, 0, 32'hDEAD_BEEF);
        wait_done("single_read");

        // Contention: reset tie-break to r0, then next tie to r1.
        lat = 1; rdata = 32'h1111_2222;
        issue(0, 32'h2000, 0, 1, 0, 1, 0, 32'h1111_2222);
        issue(1, 32'h3000, 0, 1, 0, 1, 0, 32'h1111_2222);
        wait_done("contention_a");
        issue(1, 32'h3004, 0, 1, 0, 1, 0, 32'h1111_2222);
        issue(0, 32'h2004, 0, 1, 0, 1, 0, 32'h1111_2222);
        wait_done("contention_b");

        // Read+write together performs a write only.
        lat = 2;
        issue(1, 32'h40, 32'h1234_5678, 1, 1, 2, 0, 32'h0);
        wait_done("write_both");

        // Watchdog abort, then normal traffic resumes.
        lat = 0;
        issue(0, 32'h200, 0, 1, 0, T, 1, 32'h0);
        wait_done("timeout");
        lat = 2; rdata = 32'hCAFE_0001;
        issue(0, 32'h204, 0, 1, 0, 2, 0, 32'hCAFE_0001);
        wait_done("after_timeout");

        // Ack in the same cycle as the watchdog limit wins.
        lat = T; rdata = 32'hCAFE_0002;
        issue(1, 32'h208, 0, 1, 0, T, 0, 32'hCAFE_0002);
        wait_done("ack_at_limit");

        // Reset two cycles into a read: abandoned, no completion.
        lat = 0;
        r.addr = 32'h300; r.wdata = 0; r.rd = 1; r.wr = 0;
        q0.push_back(r);
        n = 0;
        while (!mem_read_enable && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("rst_mid_started", 32'(mem_read_enable), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_rd_en", 32'(mem_read_enable), 0);
        chk("rst_mid_valid", {30'b0, r1_valid, r0_valid}, 0);
        chk("rst_mid_addr", mem_address, 0);
        q0.delete();
        #1 reset = 1'b0;
        @(posedge clk); #2;
        lat = 1; rdata = 32'h5555_AAAA;
        issue(0, 32'h400, 0, 1, 0, 1, 0, 32'h5555_AAAA);
        issue(1, 32'h500, 0, 1, 0, 1, 0, 32'h5555_AAAA);
        wait_done("post_reset_tie");

        // Constant ack, r0 back-to-back: one transaction per 3 cycles.
        always_ack = 1; use_fn = 1;
        vt.delete();
        issue(0, 32'h100, 0, 1, 0, 1, 0, 32'h0100_C0DE);
        issue(0, 32'h104, 0, 1, 0, 1, 0, 32'h0104_C0DE);
        issue(0, 32'h108, 0, 1, 0, 1, 0, 32'h0108_C0DE);
        wait_done("b2b");
        repeat (5) @(posedge clk);
        #2;
        chk("b2b_count", vt.size(), 3);
        if (vt.size() == 3) begin
            chk("b2b_gap1", vt[1] - vt[0], 3);
            chk("b2b_gap2", vt[2] - vt[1], 3);
        end
        always_ack = 0; use_fn = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
